// File: rtl/stream_checker.sv
// stream_checker: in-order scoreboard comparing actual DUT bytes against a queue of expected bytes
module stream_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exp_valid,
    input  logic [DATA_WIDTH-1:0]        exp_data,
    input  logic                         act_valid,
    input  logic [DATA_WIDTH-1:0]        act_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   exp_count,
    output logic                         exp_full,
    output logic                         exp_empty,
    output logic [CNT_WIDTH-1:0]         match_cnt,
    output logic [CNT_WIDTH-1:0]         mismatch_cnt,
    output logic [CNT_WIDTH-1:0]         underflow_cnt,
    output logic                         overflow,
    output logic                         err_pulse,
    output logic                         err_sticky,
    output logic [DATA_WIDTH-1:0]        first_exp,
    output logic [DATA_WIDTH-1:0]        first_act
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop, push, underflow, drop, match, mismatch, err_now;

    assign exp_count = count;
    assign exp_full  = count == CW'(DEPTH);
    assign exp_empty = count == '0;
    assign head      = mem[rd_ptr];

    // Queue control decode; flush suppresses every push, pop and compare in its cycle
    always_comb begin
        pop       = act_valid && !exp_empty && !flush;
        push      = exp_valid && !flush && (!exp_full || pop);
        underflow = act_valid && exp_empty && !flush;
        drop      = exp_valid && exp_full && !pop && !flush;
        match     = pop && act_data == head;
        mismatch  = pop && act_data != head;
        err_now   = mismatch || underflow;
    end

    // Circular-buffer pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Expected-data storage; contents are meaningless while not counted, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= exp_data;
    end

    // Saturating statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            underflow_cnt <= '0;
        end else begin
            if (match && match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
            if (mismatch && mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
            if (underflow && underflow_cnt != CNT_MAX) underflow_cnt <= underflow_cnt + 1'b1;
        end
    end

    // Error flags and first-failure capture; overflow alone never loads the capture regs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            first_exp  <= '0;
            first_act  <= '0;
        end else begin
            overflow   <= overflow || drop;
            err_pulse  <= err_now;
            err_sticky <= err_sticky || err_now || drop;
            if (!err_sticky && err_now) begin
                first_exp <= underflow ? '0 : head;
                first_act <= act_data;
            end
        end
    end
endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: directed and randomized checks of stream_checker against a queue-based model
module tb_stream_checker;
    localparam int DEPTH = 8;
    localparam int CNTW  = 6;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic clk = 0, reset = 1, exp_valid = 0, act_valid = 0, flush = 0;
    logic [7:0] exp_data = 0, act_data = 0;
    logic [3:0] exp_count;
    logic exp_full, exp_empty, overflow, err_pulse, err_sticky;
    logic [CNTW-1:0] match_cnt, mismatch_cnt, underflow_cnt;
    logic [7:0] first_exp, first_act;

    stream_checker #(.DATA_WIDTH(8), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_data(exp_data),
        .act_valid(act_valid), .act_data(act_data), .flush(flush),
        .exp_count(exp_count), .exp_full(exp_full), .exp_empty(exp_empty),
        .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .underflow_cnt(underflow_cnt),
        .overflow(overflow), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .first_exp(first_exp), .first_act(first_act)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    logic [7:0] mq[$];
    int m_match, m_mis, m_unf;
    logic m_ovf, m_pulse, m_sticky;
    logic [7:0] m_fe, m_fa;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_match = 0; m_mis = 0; m_unf = 0;
        m_ovf = 0; m_pulse = 0; m_sticky = 0; m_fe = 0; m_fa = 0;
    endtask

    function automatic int sat(input int v);
        return v < CMAX ? v + 1 : CMAX;
    endfunction

    task automatic model_step(input logic ev, input logic [7:0] ed, input logic av,
                              input logic [7:0] ad, input logic fl);
        logic err, dropped;
        logic [7:0] h;
        err = 0; dropped = 0;
        if (fl) mq.delete();
        else begin
            if (av) begin
                if (mq.size() == 0) begin
                    m_unf = sat(m_unf); err = 1;
                    if (!m_sticky) begin m_fe = 0; m_fa = ad; end
                end else begin
                    h = mq.pop_front();
                    if (h == ad) m_match = sat(m_match);
                    else begin
                        m_mis = sat(m_mis); err = 1;
                        if (!m_sticky) begin m_fe = h; m_fa = ad; end
                    end
                end
            end
            if (ev) begin
                if (mq.size() < DEPTH) mq.push_back(ed);
                else begin m_ovf = 1; dropped = 1; end
            end
        end
        m_pulse = err;
        if (err || dropped) m_sticky = 1;
    endtask

    task automatic check_all();
        check("exp_count", 32'(exp_count), 32'(mq.size()));
        check("exp_full", 32'(exp_full), 32'(mq.size() == DEPTH));
        check("exp_empty", 32'(exp_empty), 32'(mq.size() == 0));
        check("match_cnt", 32'(match_cnt), 32'(m_match));
        check("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mis));
        check("underflow_cnt", 32'(underflow_cnt), 32'(m_unf));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check("first_exp", 32'(first_exp), 32'(m_fe));
        check("first_act", 32'(first_act), 32'(m_fa));
    endtask

    task automatic step(input logic ev, input logic [7:0] ed, input logic av,
                        input logic [7:0] ad, input logic fl);
        exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad; flush = fl;
        @(posedge clk);
        model_step(ev, ed, av, ad, fl);
        #1;
        check_all();
        exp_valid = 0; act_valid = 0; flush = 0;
    endtask

    task automatic do_reset();
        exp_valid = 0; act_valid = 0; flush = 0;
        reset = 1;
        #2;
        model_reset();
        check("rst_count", 32'(exp_count), 0);
        check("rst_empty", 32'(exp_empty), 1);
        check("rst_match", 32'(match_cnt), 0);
        check("rst_sticky", 32'(err_sticky), 0);
        check("rst_first_act", 32'(first_act), 0);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        do_reset();
        // match path
        step(1, 8'hA5, 0, 0, 0);
        step(1, 8'h3C, 0, 0, 0);
        step(0, 0, 1, 8'hA5, 0);
        step(0, 0, 1, 8'h3C, 0);
        check("t1_match", 32'(match_cnt), 2);
        check("t1_empty", 32'(exp_empty), 1);
        // mismatch and capture hold
        step(1, 8'h0F, 0, 0, 0);
        step(0, 0, 1, 8'h0E, 0);
        check("t2_pulse", 32'(err_pulse), 1);
        check("t2_first_exp", 32'(first_exp), 32'h0F);
        check("t2_first_act", 32'(first_act), 32'h0E);
        step(1, 8'h11, 0, 0, 0);
        step(0, 0, 1, 8'h22, 0);
        check("t2_mis2", 32'(mismatch_cnt), 2);
        check("t2_first_hold", 32'(first_act), 32'h0E);
        // underflow with simultaneous push
        do_reset();
        step(1, 8'h55, 1, 8'h55, 0);
        check("t3_unf", 32'(underflow_cnt), 1);
        check("t3_count", 32'(exp_count), 1);
        check("t3_first_exp", 32'(first_exp), 0);
        check("t3_first_act", 32'(first_act), 32'h55);
        // overflow then drain
        do_reset();
        for (int i = 0; i <= DEPTH; i++) step(1, 8'(i), 0, 0, 0);
        check("t4_full", 32'(exp_full), 1);
        check("t4_ovf", 32'(overflow), 1);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(i), 0);
        check("t4_match", 32'(match_cnt), 8);
        // push+pop while full must not overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i + 16), 0, 0, 0);
        step(1, 8'h77, 1, 8'h10, 0);
        check("t4b_ovf", 32'(overflow), 0);
        check("t4b_full", 32'(exp_full), 1);
        // flush with act in same cycle
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 0, 0);
        step(1, 8'h9, 1, 8'h0, 1);
        check("t5_count", 32'(exp_count), 0);
        check("t5_unf0", 32'(underflow_cnt), 0);
        step(0, 0, 1, 8'h1, 0);
        check("t5_unf1", 32'(underflow_cnt), 1);
        // reset mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 8'(i * 7), 0, 0, 0);
            step(0, 0, 1, 8'(i * 7), 0);
        end
        for (int i = 0; i < 4; i++) step(1, 8'(i), 0, 0, 0);
        check("t6_pre_match", 32'(match_cnt), 5);
        do_reset();
        step(1, 8'hFF, 0, 0, 0);
        step(0, 0, 1, 8'hFF, 0);
        check("t6_match", 32'(match_cnt), 1);
        // randomized bursts, long enough to reach counter saturation
        for (int b = 0; b < 4; b++) begin
            do_reset();
            for (int n = 0; n < 250; n++) begin
                logic ev, av, fl;
                logic [7:0] ed, ad;
                ev = $urandom_range(0, 99) < 55;
                av = $urandom_range(0, 99) < 50;
                fl = $urandom_range(0, 99) < 4;
                ed = 8'($urandom);
                ad = 8'($urandom);
                if (mq.size() > 0 && $urandom_range(0, 2) != 0) ad = mq[0];
                step(ev, ed, av, ad, fl);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
